// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin arbiter sharing one external combinational 4-bit ALU among NREQ requesters.
module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] op_a,
  input  logic [4*NREQ-1:0] op_b,
  input  logic [3*NREQ-1:0] op_sel,
  output logic [NREQ-1:0]   grant,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_sel,
  input  logic [3:0]        alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              busy
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, pend_q, pend_d, rsp_id_q, rsp_id_d;
  logic [IDW-1:0] lo, hi, win;
  logic lo_f, hi_f;
  logic [3:0] a_w, b_w, alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
  logic [2:0] s_w, alu_sel_q, alu_sel_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
  // Descending scan: lo ends as the lowest requester, hi as the lowest at or above ptr.
  always_comb begin
    lo = '0;
    hi = '0;
    lo_f = 1'b0;
    hi_f = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) begin
        lo = IDW'(i);
        lo_f = 1'b1;
        if (IDW'(i) >= ptr_q) begin
          hi = IDW'(i);
          hi_f = 1'b1;
        end
      end
    win = hi_f ? hi : lo;
    a_w = '0;
    b_w = '0;
    s_w = '0;
    for (int i = 0; i < NREQ; i++)
      if (IDW'(i) == win) begin
        a_w = op_a[4*i +: 4];
        b_w = op_b[4*i +: 4];
        s_w = op_sel[3*i +: 3];
      end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    pend_d = pend_q;
    grant_d = '0;
    rsp_valid_d = 1'b0;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_sel_d = alu_sel_q;
    rsp_id_d = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d = rsp_zero_q;
    if (state_q == IDLE && lo_f) begin
      state_d = ISSUE;
      pend_d = win;
      grant_d = NREQ'(1) << win;
      ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      alu_a_d = a_w;
      alu_b_d = b_w;
      alu_sel_d = s_w;
    end else if (state_q == ISSUE) begin
      state_d = IDLE;
      rsp_valid_d = 1'b1;
      rsp_id_d = pend_q;
      rsp_data_d = alu_out;
      rsp_zero_d = alu_zero;
      rsp_carry_d = (alu_sel_q == 3'b000) & alu_carry;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      pend_q <= '0;
      grant_q <= '0;
      rsp_valid_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_sel_q <= '0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      pend_q <= pend_d;
      grant_q <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q <= rsp_zero_d;
    end
  assign grant = grant_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero = rsp_zero_q;
  assign busy = state_q == ISSUE;
endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one combinational 4-bit ALU between NREQ requesters. It accepts one operation at a time and drives the shared ALU's operand and select inputs from registers. It captures the ALU result, carry and zero flags, and returns them tagged with the requester ID. It sits between the requester blocks and the single ALU instance, which is wired externally through the alu_* ports.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: requester ID width; must satisfy 2**IDW >= NREQ.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; bit i held high until grant[i] is seen.
- op_a  in  4*NREQ  operand A; requester i occupies bits [4i+3:4i].
- op_b  in  4*NREQ  operand B, same packing as op_a.
- op_sel  in  3*NREQ  ALU select; requester i occupies bits [3i+2:3i].
- grant  out  NREQ  one-hot, one-cycle pulse: the request was captured.
- alu_a  out  4  operand A to the shared ALU.
- alu_b  out  4  operand B to the shared ALU.
- alu_sel  out  3  select to the shared ALU.
- alu_out  in  4  ALU result.
- alu_carry  in  1  ALU carry.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  one-cycle pulse: the response fields are valid.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  4  captured result.
- rsp_carry  out  1  captured carry, qualified by the select (see Operation).
- rsp_zero  out  1  captured zero flag.
- busy  out  1  high while an operation is in flight (state ISSUE).

## Operation
- FSM states: IDLE and ISSUE.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set, at the clock edge:
  - pick winner w by searching from ptr upward, modulo NREQ;
  - load alu_a, alu_b, alu_sel from w's slice of op_a, op_b, op_sel;
  - latch w as the pending ID;
  - grant <= one-hot(w);
  - ptr <= (w+1) mod NREQ;
  - go to ISSUE.
- ISSUE, at the next clock edge:
  - rsp_data <= alu_out;
  - rsp_zero <= alu_zero;
  - rsp_carry <= alu_carry if alu_sel==3'b000, else 0 (the ALU defines carry for add only);
  - rsp_id <= pending ID;
  - rsp_valid <= 1;
  - grant <= 0;
  - go to IDLE.
- req is ignored in ISSUE. No request is accepted while busy.
- alu_a, alu_b, alu_sel hold their last values in IDLE. They change only on acceptance.
- rsp_* fields hold their values until the next capture. Only rsp_valid pulses.
- ptr advances only on a grant. A requester that keeps req high after its grant gets a new request, served in turn.
- A bit of req at or above NREQ does not exist. Only bits 0..NREQ-1 take part in arbitration.

## Timing
- Reset (async, rst=1) values:
  - state=IDLE, ptr=0;
  - grant, rsp_valid, busy = 0;
  - alu_a, alu_b, alu_sel, rsp_id, rsp_data, rsp_carry, rsp_zero = 0.
- Latency:
  - acceptance edge E;
  - grant and busy high during cycle E..E+1;
  - ALU evaluates during that cycle;
  - capture at edge E+1;
  - rsp_valid high during cycle E+1..E+2.
- Throughput: one operation per 2 cycles.
- The cycle in which rsp_valid is high is an IDLE cycle. A new request can be accepted at its closing edge, giving back-to-back rsp_valid pulses every second cycle.
- Requesters must hold op_a, op_b, op_sel stable while req is high and not yet granted. The arbiter samples them only at the acceptance edge.
- Reset asserted during ISSUE:
  - the pending operation is discarded;
  - no rsp_valid pulse is produced;
  - all outputs return to their reset values immediately.

## Test plan
- Single request: req=0001, a=3, b=5, sel=000 -> grant=0001 for 1 cycle, then rsp_valid with rsp_id=0, data=8, carry=0, zero=0.
- Add overflow: req1, a=15, b=1, sel=000 -> rsp_id=1, data=0, carry=1, zero=1.
- Carry qualification: req2, a=5, b=5, sel=001, with alu_carry still 1 from the previous add -> data=0, zero=1, carry=0.
- Fairness: req=1111 held, each bit dropped after its grant -> grant order 0,1,2,3. rsp_valid pulses every 2 cycles. ptr returns to 0.
- Rotation: after the grant to 2, assert req=0101 -> grant 0 before grant 2. With req=0101 and ptr=3 -> grant 0, then 2.
- Reset mid-operation: assert rst during the ISSUE cycle of req0 -> no rsp_valid. All outputs are 0. The next req=0010 is granted first (ptr=0 path, winner 1).
